// File: rtl/sobol_rng_multi.sv
// rtl/sobol_rng_multi.sv - multi-dimensional Sobol low-discrepancy sequence generator
//
// One shared index counter and least-significant-zero detector drive NUM_DIM
// XOR accumulators (Gray-code ordered Sobol construction). Direction vectors
// are elaboration constants built from fixed primitive-polynomial recurrences.
//
// Parameters:
//   WIDTH    bits per sample and index counter width (2..16)
//   NUM_DIM  number of dimensions (1..3)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (priority over restart/enable)
//   enable      advance the sequence one step
//   restart     synchronous return to index 0
//   sobol_seq   samples, dimension d at [d*WIDTH +: WIDTH]
//   idx         index of the sample currently on sobol_seq
//   period_end  one-cycle pulse after the step that wrapped the period
//
// Optional feature, macro SOBOL_SCRAMBLE_EN: adds shift_load/shift_val and a
// digital-shift register XORed onto sobol_seq.

module sobol_rng_multi #(
    parameter int WIDTH   = 8,
    parameter int NUM_DIM = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       restart,
`ifdef SOBOL_SCRAMBLE_EN
    input  logic                       shift_load,
    input  logic [NUM_DIM*WIDTH-1:0]   shift_val,
`endif
    output logic [NUM_DIM*WIDTH-1:0]   sobol_seq,
    output logic [WIDTH-1:0]           idx,
    output logic                       period_end
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (NUM_DIM < 1 || NUM_DIM > 3) begin : g_bad_num_dim
        $error("sobol_rng_multi: NUM_DIM must be 1..3");
    end
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("sobol_rng_multi: WIDTH must be 2..16");
    end

    // Direction vector v_k for one dimension; only shifts right and XORs of
    // in-range values, so everything stays within WIDTH bits.
    function automatic logic [WIDTH-1:0] dir_vec(input int dim, input int k);
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] vm1;
        logic [WIDTH-1:0] vm2;
        logic [WIDTH-1:0] v;
        top = {1'b1, {(WIDTH-1){1'b0}}};
        vm2 = '0;
        vm1 = top;
        v   = top;
        for (int j = 2; j <= k; j++) begin
            case (dim)
                0:       v = vm1 >> 1;
                1:       v = vm1 ^ (vm1 >> 1);
                default: v = (j == 2) ? (top | (top >> 1)) : (vm1 ^ vm2 ^ (vm2 >> 2));
            endcase
            vm2 = vm1;
            vm1 = v;
        end
        return v;
    endfunction

    logic [WIDTH-1:0] dir_tab [NUM_DIM][WIDTH];

    for (genvar gd = 0; gd < NUM_DIM; gd++) begin : g_dim
        for (genvar gk = 0; gk < WIDTH; gk++) begin : g_k
            localparam logic [WIDTH-1:0] V = dir_vec(gd, gk + 1);
            assign dir_tab[gd][gk] = V;
        end
    end

    logic [WIDTH-1:0]         idx_q, idx_d;
    logic [NUM_DIM*WIDTH-1:0] acc_q, acc_d;
    logic                     pe_q, pe_d;
    logic [PW-1:0]            lsz;

    // Priority encoder for the lowest zero bit of idx; scanning downward lets
    // the lowest match win. All-ones is handled by the wrap path instead.
    always_comb begin
        lsz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!idx_q[i]) lsz = PW'(i);
        end
    end

    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        pe_d  = 1'b0;
        if (restart) begin
            idx_d = '0;
            acc_d = '0;
        end else if (enable) begin
            if (&idx_q) begin
                // Wrap to index 0 rather than taking a step: keeps the period
                // exactly 2^WIDTH enables and realigns every dimension at zero.
                idx_d = '0;
                acc_d = '0;
                pe_d  = 1'b1;
            end else begin
                idx_d = idx_q + WIDTH'(1);
                for (int d = 0; d < NUM_DIM; d++) begin
                    acc_d[d*WIDTH +: WIDTH] = acc_q[d*WIDTH +: WIDTH] ^ dir_tab[d][lsz];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            acc_q <= '0;
            pe_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
            pe_q  <= pe_d;
        end
    end

`ifdef SOBOL_SCRAMBLE_EN
    logic [NUM_DIM*WIDTH-1:0] shift_q, shift_d;

    always_comb begin
        shift_d = shift_q;
        if (shift_load) shift_d = shift_val;
    end

    always_ff @(posedge clk) begin
        if (rst) shift_q <= '0;
        else     shift_q <= shift_d;
    end

    assign sobol_seq = acc_q ^ shift_q;
`else
    assign sobol_seq = acc_q;
`endif

    assign idx        = idx_q;
    assign period_end = pe_q;

endmodule

// File: tb/tb_sobol_rng_multi.sv
// tb/tb_sobol_rng_multi.sv - directed vector bench for sobol_rng_multi
module tb_sobol_rng_multi;

    logic        clk;
    logic        rst;
    logic        en_a, rs_a, en_b, rs_b;
    logic [11:0] seq_a;
    logic [3:0]  idx_a;
    logic        pe_a;
    logic [7:0]  seq_b;
    logic [7:0]  idx_b;
    logic        pe_b;
`ifdef SOBOL_SCRAMBLE_EN
    logic        sl_a, sl_b;
    logic [11:0] sv_a;
    logic [7:0]  sv_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    sobol_rng_multi #(.WIDTH(4), .NUM_DIM(3)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_a),
        .restart    (rs_a),
`ifdef SOBOL_SCRAMBLE_EN
        .shift_load (sl_a),
        .shift_val  (sv_a),
`endif
        .sobol_seq  (seq_a),
        .idx        (idx_a),
        .period_end (pe_a)
    );

    sobol_rng_multi #(.WIDTH(8), .NUM_DIM(1)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_b),
        .restart    (rs_b),
`ifdef SOBOL_SCRAMBLE_EN
        .shift_load (sl_b),
        .shift_val  (sv_b),
`endif
        .sobol_seq  (seq_b),
        .idx        (idx_b),
        .period_end (pe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       restart;
        logic       enable;
        logic [3:0] e_idx;
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] e2;
        logic       e_pe;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic r, input logic rs, input logic en,
                                input logic [3:0] ei, input logic [3:0] e0, input logic [3:0] e1,
                                input logic [3:0] e2, input logic ep);
        vec_t v;
        v.name = nm; v.rst = r; v.restart = rs; v.enable = en;
        v.e_idx = ei; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e_pe = ep;
        return v;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string nm, input logic [3:0] ei, input logic [3:0] e0,
                           input logic [3:0] e1, input logic [3:0] e2, input logic ep);
        n_vec++;
        if (idx_a !== ei || seq_a[3:0] !== e0 || seq_a[7:4] !== e1 || seq_a[11:8] !== e2 || pe_a !== ep) begin
            n_err++;
            $display("FAIL %s: got idx=%0d d0=%0d d1=%0d d2=%0d pe=%0b, want idx=%0d d0=%0d d1=%0d d2=%0d pe=%0b",
                     nm, idx_a, seq_a[3:0], seq_a[7:4], seq_a[11:8], pe_a, ei, e0, e1, e2, ep);
        end
    endtask

    vec_t tbl[$];
    logic [15:0] seen0, seen1, seen2;
    logic [7:0]  exp_b;

    initial begin
        rst = 1'b1; en_a = 1'b0; rs_a = 1'b0; en_b = 1'b0; rs_b = 1'b0;
`ifdef SOBOL_SCRAMBLE_EN
        sl_a = 1'b0; sv_a = '0; sl_b = 1'b0; sv_b = '0;
`endif

        // WIDTH=4 direction vectors: dim0 8,4,2,1; dim1 8,12,10,15; dim2 8,12,6,9
        tbl.push_back(mk("reset",        1, 0, 1, 0,  0,  0,  0, 0));
        tbl.push_back(mk("step1",        0, 0, 1, 1,  8,  8,  8, 0));
        tbl.push_back(mk("step2",        0, 0, 1, 2, 12,  4,  4, 0));
        tbl.push_back(mk("step3",        0, 0, 1, 3,  4, 12, 12, 0));
        tbl.push_back(mk("step4",        0, 0, 1, 4,  6,  6, 10, 0));
        tbl.push_back(mk("step5",        0, 0, 1, 5, 14, 14,  2, 0));
        tbl.push_back(mk("hold1",        0, 0, 0, 5, 14, 14,  2, 0));
        tbl.push_back(mk("hold2",        0, 0, 0, 5, 14, 14,  2, 0));
        tbl.push_back(mk("step6",        0, 0, 1, 6, 10,  2, 14, 0));
        tbl.push_back(mk("step7",        0, 0, 1, 7,  2, 10,  6, 0));
        tbl.push_back(mk("restart_en",   0, 1, 1, 0,  0,  0,  0, 0));
        tbl.push_back(mk("after_restart",0, 0, 1, 1,  8,  8,  8, 0));
        tbl.push_back(mk("rst_restart",  1, 1, 1, 0,  0,  0,  0, 0));
        tbl.push_back(mk("idle",         0, 0, 0, 0,  0,  0,  0, 0));

        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            rs_a = tbl[i].restart;
            en_a = tbl[i].enable;
            tick();
            check_a(tbl[i].name, tbl[i].e_idx, tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e_pe);
        end

        // Full period on the 4-bit, 3-dimension instance
        rst = 1'b1; rs_a = 1'b0; en_a = 1'b0;
        tick();
        rst = 1'b0; en_a = 1'b1;
        seen0 = 16'h0001; seen1 = 16'h0001; seen2 = 16'h0001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                n_vec++;
                if (idx_a !== 4'(k) || pe_a !== 1'b0) begin
                    n_err++;
                    $display("FAIL period_step%0d: got idx=%0d pe=%0b, want idx=%0d pe=0", k, idx_a, pe_a, k);
                end
                seen0[seq_a[3:0]]  = 1'b1;
                seen1[seq_a[7:4]]  = 1'b1;
                seen2[seq_a[11:8]] = 1'b1;
            end else begin
                check_a("wrap", 0, 0, 0, 0, 1);
            end
        end
        en_a = 1'b0;
        tick();
        check_a("wrap_pulse_end", 0, 0, 0, 0, 0);
        n_vec++;
        if (seen0 !== 16'hFFFF) begin n_err++; $display("FAIL cover_dim0: got mask=%h, want ffff", seen0); end
        n_vec++;
        if (seen1 !== 16'hFFFF) begin n_err++; $display("FAIL cover_dim1: got mask=%h, want ffff", seen1); end
        n_vec++;
        if (seen2 !== 16'hFFFF) begin n_err++; $display("FAIL cover_dim2: got mask=%h, want ffff", seen2); end

        // 8-bit, 1-dimension instance: dim0 is the bit-reversed Gray code of idx
        rst = 1'b1; en_b = 1'b0;
        tick();
        rst = 1'b0; en_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_b = rev8(8'(i) ^ (8'(i) >> 1));
            n_vec++;
            if (idx_b !== 8'(i) || seq_b !== exp_b || pe_b !== 1'b0) begin
                n_err++;
                $display("FAIL w8_step%0d: got idx=%0d d0=%0d pe=%0b, want idx=%0d d0=%0d pe=0",
                         i, idx_b, seq_b, pe_b, i, exp_b);
            end
            tick();
        end
        n_vec++;
        if (idx_b !== 8'd0 || seq_b !== 8'd0 || pe_b !== 1'b1) begin
            n_err++;
            $display("FAIL w8_wrap: got idx=%0d d0=%0d pe=%0b, want idx=0 d0=0 pe=1", idx_b, seq_b, pe_b);
        end
        en_b = 1'b0;
        tick();
        n_vec++;
        if (pe_b !== 1'b0 || idx_b !== 8'd0) begin
            n_err++;
            $display("FAIL w8_pulse_end: got idx=%0d pe=%0b, want idx=0 pe=0", idx_b, pe_b);
        end

`ifdef SOBOL_SCRAMBLE_EN
        rst = 1'b1; en_a = 1'b0;
        tick();
        rst = 1'b0; sl_a = 1'b1; sv_a = 12'h00F;
        tick();
        check_a("scr_load", 0, 15, 0, 0, 0);
        sl_a = 1'b0; en_a = 1'b1;
        tick();
        check_a("scr_idx1", 1, 7, 8, 8, 0);
        tick();
        check_a("scr_idx2", 2, 3, 4, 4, 0);
        tick();
        check_a("scr_idx3", 3, 11, 12, 12, 0);
        en_a = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
